// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall responder: watchdog state encoding
// and the NOP values that squashed or bubbled pipeline registers are loaded with.
package pipe_ctrl_pkg;

  localparam int CTRL_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HOLD = 2'b01,
    ERR  = 2'b10
  } stall_state_t;

  localparam logic [31:0]         NOP_INSTR = 32'h0;
  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stall_responder_stall_watchdog.sv
// Stall watchdog: counts consecutive Stall cycles and latches a sticky timeout
// once more than MAX_STALL consecutive stalls have been seen.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Stall,
  output logic StallActive,
  output logic StallTimeout
);

  localparam int CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  stall_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             active_reg, active_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= RUN;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      active_reg <= active_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (Stall) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      HOLD: begin
        if (Stall) begin
          if (cnt_reg == CNT_W'(MAX_STALL)) begin
            state_next = ERR;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
    // Once in ERR the flag just mirrors the previous cycle's Stall.
    active_next = (state_next == ERR) ? Stall : (state_next == HOLD);
  end

  assign StallActive  = active_reg;
  assign StallTimeout = (state_reg == ERR);

endmodule

// File: rtl/pipe_stall_responder.sv
// PC, IF/ID and ID/EX registers driven by the hazard-detector hold/bubble/flush
// controls, plus the stall watchdog. Optional STALL_PERF_CNT_EN adds perf counters.
module pipe_stall_responder
  import pipe_ctrl_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CTRL_W    = CTRL_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int          MAX_STALL = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic              IF_IDWrite,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [DATA_W-1:0] PCNext,
  input  logic [DATA_W-1:0] Instr_in,
  input  logic [DATA_W-1:0] PCPlus4_in,
  input  logic [CTRL_W-1:0] Ctrl_in,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IF_ID_Instr,
  output logic [DATA_W-1:0] IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              ID_EX_Valid,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushCount,
`endif
  output logic              StallActive,
  output logic              StallTimeout
);

  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] if_id_instr_reg, if_id_pcplus4_reg;
  logic              if_id_valid_reg;
  logic [CTRL_W-1:0] id_ex_ctrl_reg;
  logic              id_ex_valid_reg;

  // Flush wins over the hold requests: a redirect must never be lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg <= RESET_PC;
    end else if (Flush || PCWrite) begin
      pc_reg <= PCNext;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      if_id_instr_reg   <= DATA_W'(NOP_INSTR);
      if_id_pcplus4_reg <= '0;
      if_id_valid_reg   <= 1'b0;
    end else if (IF_IDWrite) begin
      if_id_instr_reg   <= Instr_in;
      if_id_pcplus4_reg <= PCPlus4_in;
      if_id_valid_reg   <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Stall) begin
      id_ex_ctrl_reg  <= CTRL_W'(NOP_CTRL);
      id_ex_valid_reg <= 1'b0;
    end else begin
      id_ex_ctrl_reg  <= Ctrl_in;
      id_ex_valid_reg <= if_id_valid_reg;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_reg, flush_count_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (Stall) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (Flush) flush_count_reg  <= flush_count_reg + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_reg;
  assign FlushCount  = flush_count_reg;
`endif

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .StallActive  (StallActive),
    .StallTimeout (StallTimeout)
  );

  assign PC            = pc_reg;
  assign IF_ID_Instr   = if_id_instr_reg;
  assign IF_ID_PCPlus4 = if_id_pcplus4_reg;
  assign IF_ID_Valid   = if_id_valid_reg;
  assign ID_EX_Ctrl    = id_ex_ctrl_reg;
  assign ID_EX_Valid   = id_ex_valid_reg;

endmodule

// File: tb/tb_pipe_stall_responder.sv
// Directed bench for pipe_stall_responder; perf counter checks only when
// STALL_PERF_CNT_EN is defined.
module tb_pipe_stall_responder;

  logic        Clk = 1'b0;
  logic        Reset, PCWrite, IF_IDWrite, Stall, Flush;
  logic [31:0] PCNext, Instr_in, PCPlus4_in;
  logic [15:0] Ctrl_in;
  logic [31:0] PC, IF_ID_Instr, IF_ID_PCPlus4;
  logic        IF_ID_Valid, ID_EX_Valid, StallActive, StallTimeout;
  logic [15:0] ID_EX_Ctrl;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pipe_stall_responder dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PCWrite       (PCWrite),
    .IF_IDWrite    (IF_IDWrite),
    .Stall         (Stall),
    .Flush         (Flush),
    .PCNext        (PCNext),
    .Instr_in      (Instr_in),
    .PCPlus4_in    (PCPlus4_in),
    .Ctrl_in       (Ctrl_in),
    .PC            (PC),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
    .IF_ID_Valid   (IF_ID_Valid),
    .ID_EX_Ctrl    (ID_EX_Ctrl),
    .ID_EX_Valid   (ID_EX_Valid),
`ifdef STALL_PERF_CNT_EN
    .StallCycles   (StallCycles),
    .FlushCount    (FlushCount),
`endif
    .StallActive   (StallActive),
    .StallTimeout  (StallTimeout)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic st, input logic fl,
                       input logic [31:0] pcn, input logic [31:0] ins, input logic [31:0] p4,
                       input logic [15:0] ctl);
    PCWrite = pcw; IF_IDWrite = ifw; Stall = st; Flush = fl;
    PCNext = pcn; Instr_in = ins; PCPlus4_in = p4; Ctrl_in = ctl;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234, 32'hDEAD, 32'hBEEF, 16'hFFFF);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0);
    checks++;
    if (PC !== 32'h0 || IF_ID_Instr !== 32'h0 || IF_ID_PCPlus4 !== 32'h0 || IF_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ifid: PC=%h instr=%h p4=%h v=%b required 0/0/0/0", PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid);
    end
    checks++;
    if (ID_EX_Ctrl !== 16'h0 || ID_EX_Valid !== 1'b0 || StallActive !== 1'b0 || StallTimeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_idex: ctrl=%h v=%b act=%b to=%b required 0/0/0/0", ID_EX_Ctrl, ID_EX_Valid, StallActive, StallTimeout);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'hAAAA0001, 32'h4, 16'h00F1);
    step();
    checks++;
    if (PC !== 32'h4 || IF_ID_Instr !== 32'hAAAA0001 || IF_ID_PCPlus4 !== 32'h4 || IF_ID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL normal1_ifid: PC=%h instr=%h p4=%h v=%b required 4/aaaa0001/4/1", PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid);
    end
    checks++;
    if (ID_EX_Ctrl !== 16'h00F1 || ID_EX_Valid !== 1'b0) begin
      errors++;
      $display("FAIL normal1_idex: ctrl=%h v=%b required 00f1/0", ID_EX_Ctrl, ID_EX_Valid);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'hAAAA0002, 32'h8, 16'h00F2);
    step();
    checks++;
    if (PC !== 32'h8 || IF_ID_Instr !== 32'hAAAA0002 || ID_EX_Ctrl !== 16'h00F2 || ID_EX_Valid !== 1'b1) begin
      errors++;
      $display("FAIL normal2: PC=%h instr=%h ctrl=%h v=%b required 8/aaaa0002/00f2/1", PC, IF_ID_Instr, ID_EX_Ctrl, ID_EX_Valid);
    end
    $display("test_normal done");
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hC, 32'hAAAA0003, 32'hC, 16'h00F3);
    step();
    checks++;
    if (PC !== 32'h8 || IF_ID_Instr !== 32'hAAAA0002 || IF_ID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_hold: PC=%h instr=%h v=%b required 8/aaaa0002/1", PC, IF_ID_Instr, IF_ID_Valid);
    end
    checks++;
    if (ID_EX_Ctrl !== 16'h0 || ID_EX_Valid !== 1'b0 || StallActive !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_bubble: ctrl=%h v=%b act=%b required 0/0/1", ID_EX_Ctrl, ID_EX_Valid, StallActive);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'hAAAA0003, 32'hC, 16'h00F4);
    step();
    checks++;
    if (PC !== 32'hC || ID_EX_Ctrl !== 16'h00F4 || ID_EX_Valid !== 1'b1 || StallActive !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_resume: PC=%h ctrl=%h v=%b act=%b required c/00f4/1/0", PC, ID_EX_Ctrl, ID_EX_Valid, StallActive);
    end
    $display("test_load_use done");
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'hAAAA0004, 32'h10, 16'h00F5);
    step();
    checks++;
    if (PC !== 32'h40 || IF_ID_Instr !== 32'h0 || IF_ID_PCPlus4 !== 32'h0 || IF_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ifid: PC=%h instr=%h p4=%h v=%b required 40/0/0/0", PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid);
    end
    checks++;
    if (ID_EX_Ctrl !== 16'h00F5 || ID_EX_Valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_idex: ctrl=%h v=%b required 00f5/1", ID_EX_Ctrl, ID_EX_Valid);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 32'hAAAA0005, 32'h44, 16'h00F6);
    step();
    checks++;
    if (PC !== 32'h44 || IF_ID_Valid !== 1'b1 || ID_EX_Ctrl !== 16'h00F6 || ID_EX_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: PC=%h ifv=%b ctrl=%h exv=%b required 44/1/00f6/0", PC, IF_ID_Valid, ID_EX_Ctrl, ID_EX_Valid);
    end
    $display("test_flush done");
  endtask

  task automatic test_flush_stall();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'hAAAA0006, 32'h48, 16'h00F7);
    step();
    checks++;
    if (PC !== 32'h80 || IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0 || ID_EX_Ctrl !== 16'h0 || ID_EX_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: PC=%h ifv=%b instr=%h ctrl=%h exv=%b required 80/0/0/0/0", PC, IF_ID_Valid, IF_ID_Instr, ID_EX_Ctrl, ID_EX_Valid);
    end
    checks++;
    if (StallActive !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_active: act=%b required 1", StallActive);
    end
    $display("test_flush_stall done");
  endtask

  task automatic test_inconsistent();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h84, 32'hAAAA0007, 32'h84, 16'h00F8);
    step();
    checks++;
    if (PC !== 32'h84 || IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0 || StallActive !== 1'b0) begin
      errors++;
      $display("FAIL inconsistent: PC=%h ifv=%b instr=%h act=%b required 84/0/0/0", PC, IF_ID_Valid, IF_ID_Instr, StallActive);
    end
    $display("test_inconsistent done");
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (StallTimeout !== 1'b0 || StallActive !== 1'b1) begin
        errors++;
        $display("FAIL timeout_legal_%0d: to=%b act=%b required 0/1", i, StallTimeout, StallActive);
      end
    end
    step();
    checks++;
    if (StallTimeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: to=%b required 1", StallTimeout);
    end
    Stall = 1'b0;
    step();
    step();
    checks++;
    if (StallTimeout !== 1'b1 || StallActive !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: to=%b act=%b required 1/0", StallTimeout, StallActive);
    end
    do_reset();
    checks++;
    if (StallTimeout !== 1'b0 || StallActive !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: to=%b act=%b required 0/0", StallTimeout, StallActive);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hBBBB0001, 32'h104, 16'h0A0A);
    step();
    Reset = 1'b1;
    step();
    checks++;
    if (PC !== 32'h0 || IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0 || ID_EX_Valid !== 1'b0 ||
        ID_EX_Ctrl !== 16'h0 || StallActive !== 1'b0 || StallTimeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: PC=%h ifv=%b instr=%h exv=%b ctrl=%h act=%b to=%b required all 0",
               PC, IF_ID_Valid, IF_ID_Instr, ID_EX_Valid, ID_EX_Ctrl, StallActive, StallTimeout);
    end
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0);
    step();
    step();
    step();
    checks++;
    if (StallActive !== 1'b1 || StallTimeout !== 1'b0) begin
      errors++;
      $display("FAIL restall: act=%b to=%b required 1/0", StallActive, StallTimeout);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 16'h0);
    step();
    step();
    Flush = 1'b0;
    checks++;
    if (PC !== 32'h200 || StallActive !== 1'b0) begin
      errors++;
      $display("FAIL flush_pair: PC=%h act=%b required 200/0", PC, StallActive);
    end
`ifdef STALL_PERF_CNT_EN
    checks++;
    if (StallCycles !== 32'd3 || FlushCount !== 32'd2) begin
      errors++;
      $display("FAIL perf_counts: stalls=%0d flushes=%0d required 3/2", StallCycles, FlushCount);
    end
`endif
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0);
    test_reset();
    test_normal();
    test_load_use();
    test_flush();
    test_flush_stall();
    test_inconsistent();
    test_timeout();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
